// File: rtl/nbit_multiplier.sv
// nbit_multiplier: unsigned m*q shown in decimal on 7-segment digits; optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
module nbit_multiplier #(
  parameter int N = 4,
  parameter int DISPLAY_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 m,
  input  logic [N-1:0]                 q,
  output logic [7*DISPLAY_WIDTH-1:0]   displaySeg
);
  localparam int W = 2 * N;
  localparam int ND = (W * 30103) / 100000 + 1;
  localparam int NB = ND > DISPLAY_WIDTH ? ND : DISPLAY_WIDTH;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;
  logic [W-1:0] p;
  logic [4*ND-1:0] bcd;
  logic [4*NB-1:0] digits;
  logic ovf;
  logic [3:0] dig;
  logic blank;
  logic [7*DISPLAY_WIDTH-1:0] seg_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
`endif
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = BLANK;
    endcase
  endfunction
  assign p = W'(m) * W'(q);
  // shift-add-3 conversion of the full-width product to packed BCD
  always_comb begin
    bcd = '0;
    for (int i = W - 1; i >= 0; i--) begin
      for (int d = 0; d < ND; d++)
        bcd[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
      bcd = {bcd[4*ND-2:0], p[i]};
    end
  end
  // pad BCD to cover the display and flag any nonzero digit beyond it
  always_comb begin
    digits = '0;
    digits[4*ND-1:0] = bcd;
    ovf = |(digits >> (4 * DISPLAY_WIDTH));
  end
  // per-digit encoding, scanning from the top so leading zeros can be tracked
  always_comb begin
    seg_next = '1;
    dig = '0;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
`endif
    for (int k = DISPLAY_WIDTH - 1; k >= 0; k--) begin
      dig = digits[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && dig == 4'd0;
      blank = lead && k != 0;
`else
      blank = 1'b0;
`endif
      seg_next[7*k +: 7] = ovf ? DASH : blank ? BLANK : seg7(dig);
    end
  end
  // single output register; reset blanks every digit
  always_ff @(posedge clk)
    if (rst) displaySeg <= '1;
    else displaySeg <= seg_next;
endmodule

// File: tb/tb_nbit_multiplier.sv
// tb_nbit_multiplier: directed and sweep checks of the 7-segment product display
module tb_nbit_multiplier;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] m, q;
  logic [20:0] seg3;
  logic [13:0] seg2;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S5 = 7'b0010010,
                         S9 = 7'b0010000, BL = 7'b1111111, DA = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif
  logic [6:0] tab [0:9];
  nbit_multiplier #(.N(4), .DISPLAY_WIDTH(3)) dut3 (.clk(clk), .rst(rst), .m(m), .q(q), .displaySeg(seg3));
  nbit_multiplier #(.N(4), .DISPLAY_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .m(m), .q(q), .displaySeg(seg2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask
  function automatic logic [20:0] model(input int p, input int dw);
    logic [20:0] r = '0;
    int pw = 1;
    int lim = 1;
    for (int k = 0; k < dw; k++) lim *= 10;
    for (int k = 0; k < dw; k++) begin
      if (p >= lim) r[7*k +: 7] = DA;
`ifdef LEADING_ZERO_BLANK_EN
      else if (k > 0 && p < pw) r[7*k +: 7] = BL;
`endif
      else r[7*k +: 7] = tab[(p / pw) % 10];
      pw *= 10;
    end
    return r;
  endfunction
  task automatic step(input logic [3:0] a, input logic [3:0] b);
    m = a;
    q = b;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    rst = 1'b1;
    step(4'd5, 4'd5);
    chk("reset1", seg3, 21'h1FFFFF);
    chk("reset1_dw2", {7'b0, seg2}, {7'b0, 14'h3FFF});
    step(4'd5, 4'd5);
    chk("reset2", seg3, 21'h1FFFFF);
    rst = 1'b0;
    step(4'd5, 4'd5);
    chk("p25", seg3, {LZ, S2, S5});
    step(4'd0, 4'd9);
    chk("zero", seg3, {LZ, LZ, S0});
    chk("zero_dw2", {7'b0, seg2}, {7'b0, LZ, S0});
    step(4'd15, 4'd15);
    chk("p225", seg3, {S2, S2, S5});
    chk("ovf_dw2", {7'b0, seg2}, {7'b0, DA, DA});
    step(4'd7, 4'd3);
    chk("p21", seg3, {LZ, S2, S1});
    step(4'd9, 4'd11);
    chk("p99_dw2", {7'b0, seg2}, {7'b0, S9, S9});
    chk("p99", seg3, {LZ, S9, S9});
    step(4'd10, 4'd10);
    chk("p100_dw2", {7'b0, seg2}, {7'b0, DA, DA});
    chk("p100", seg3, {S1, S0, S0});
    m = 4'd3;
    q = 4'd4;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset", seg3, 21'h1FFFFF);
    rst = 1'b0;
    step(4'd3, 4'd4);
    chk("after_midreset", seg3, {LZ, S1, S2});
    for (int b = 0; b < 16; b++)
      for (int a = 0; a < 16; a++) begin
        step(4'(a), 4'(b));
        chk("sweep_dw3", seg3, model(a * b, 3));
        chk("sweep_dw2", {7'b0, seg2}, model(a * b, 2));
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
